alu_multicycle: RTL and testbench

//  Parametrised ALU that adds iterative multiply/divide and HI/LO registers to the legacy 3-bit op set.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_multicycle_if.sv | 25 ++
 rtl/alu_muldiv_iter.sv | 96 +++++++++
 rtl/alu_multicycle.sv | 129 ++++++++++++
 tb/tb_alu_multicycle.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and op-class helpers for alu_multicycle
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_MFHI  = 4'b1100;
  localparam logic [3:0] OP_MFLO  = 4'b1101;
  localparam logic [3:0] OP_RSV0  = 4'b1110;
  localparam logic [3:0] OP_RSV1  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } alu_state_t;

  // Reserved opcodes fall through to a zero result in a single cycle.
  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// rtl/alu_multicycle_if.sv - request/result bundle between the EX stage and alu_multicycle
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ALU_Control;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALU_result;
  logic             zero;
  logic             overflow;
  logic             div_by_zero;

  modport master (
    output start, ALU_Control, A, B,
    input  busy, done, ALU_result, zero, overflow, div_by_zero
  );

  modport slave (
    input  start, ALU_Control, A, B,
    output busy, done, ALU_result, zero, overflow, div_by_zero
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - iterative shift-add multiplier / restoring divider on operand magnitudes
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             op_is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             finish
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(WIDTH);

  logic [WIDTH-1:0]   opnd_b;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               div_mode;
  logic               neg_q;
  logic               neg_r;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] step_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // acc holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient bits}.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_b} : '0);
    rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, opnd_b};
    if (!div_mode) begin
      step_next = {mul_sum, acc[WIDTH-1:1]};
    end else if (diff[WIDTH]) begin
      step_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      step_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opnd_b   <= '0;
      acc      <= '0;
      cnt      <= CNT_END;
      div_mode <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else if (go) begin
      opnd_b   <= b_mag;
      acc      <= {{WIDTH{1'b0}}, a_mag};
      cnt      <= '0;
      div_mode <= op_is_div;
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
    end else if (cnt != CNT_END) begin
      acc <= step_next;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Asserted during the cycle whose edge performs the last step.
  assign finish = (cnt == CNT_LAST);

  // A zero divisor leaves rem = |A|, so the remainder sign fix restores A itself.
  always_comb begin
    prod = neg_q ? -acc : acc;
    rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (opnd_b == '0) begin
      quot = '1;
    end else begin
      quot = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end
    hi = div_mode ? rem  : prod[2*WIDTH-1:WIDTH];
    lo = div_mode ? quot : prod[WIDTH-1:0];
  end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - EX-stage ALU with single-cycle logic ops and iterative mul/div into HI/LO
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  alu_multicycle_if.slave  bus
);

  alu_state_t       state, state_next;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, ovf_q, dz_q, done_q;
  logic             dz_pend;

  logic [3:0]       op;
  logic             accept, iter_op, go, finish;
  logic [WIDTH-1:0] sum, dif;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;
  logic [WIDTH-1:0] eng_hi, eng_lo;

  assign op      = bus.ALU_Control;
  assign iter_op = is_iter_op(op);
  assign accept  = (state == ST_IDLE) && bus.start;
  assign go      = accept && iter_op;
  assign sum     = bus.A + bus.B;
  assign dif     = bus.A - bus.B;

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    case (op)
      OP_AND:  res_c = bus.A & bus.B;
      OP_OR:   res_c = bus.A | bus.B;
      OP_XOR:  res_c = bus.A ^ bus.B;
      OP_NOR:  res_c = ~(bus.A | bus.B);
      OP_ADD: begin
        res_c = sum;
        ovf_c = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = dif;
        ovf_c = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (dif[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      OP_MFHI: res_c = hi_q;
      OP_MFLO: res_c = lo_q;
      default: res_c = '0;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .op_is_div (is_div_op(op)),
    .is_signed (is_signed_op(op)),
    .a         (bus.A),
    .b         (bus.B),
    .hi        (eng_hi),
    .lo        (eng_lo),
    .finish    (finish)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (go)     state_next = ST_CALC;
      ST_CALC: if (finish) state_next = ST_FIX;
      ST_FIX:              state_next = ST_IDLE;
      default:             state_next = ST_IDLE;
    endcase
  end

  // Result/flags are only touched by an accepted single-cycle op or the FIX write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      dz_pend  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept && !iter_op) begin
        result_q <= res_c;
        zero_q   <= (res_c == '0);
        ovf_q    <= ovf_c;
        dz_q     <= 1'b0;
        done_q   <= 1'b1;
      end
      if (go) begin
        dz_pend <= is_div_op(op) && (bus.B == '0);
      end
      if (state == ST_FIX) begin
        hi_q     <= eng_hi;
        lo_q     <= eng_lo;
        result_q <= eng_lo;
        zero_q   <= (eng_lo == '0);
        ovf_q    <= 1'b0;
        dz_q     <= dz_pend;
        done_q   <= 1'b1;
      end
    end
  end

  assign bus.busy        = (state != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.ALU_result  = result_q;
  assign bus.zero        = zero_q;
  assign bus.overflow    = ovf_q;
  assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - directed and random checks of alu_multicycle against an arithmetic model
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  alu_multicycle_if #(.WIDTH(W)) bus ();

  alu_multicycle #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: HI/LO semantics from signed/unsigned integer arithmetic.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic ovf, output logic dz);
    longint sa, sb, s;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = a;
    ib = b;
    res = '0;
    ovf = 1'b0;
    dz  = 1'b0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOR:  res = ~(a | b);
      OP_ADD: begin s = sa + sb; res = s[W-1:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      OP_SUB: begin s = sa - sb; res = s[W-1:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      OP_SLT:  res = (sa < sb) ? 1 : 0;
      OP_SLTU: res = (a < b) ? 1 : 0;
      OP_MULT: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo; end
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo; end
      OP_DIV, OP_DIVU: begin
        if (b == 0) begin
          m_lo = '1; m_hi = a; dz = 1'b1;
        end else if (op == OP_DIVU) begin
          m_lo = a / b; m_hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000; m_hi = '0;
        end else begin
          m_lo = ia / ib; m_hi = ia % ib;
        end
        res = m_lo;
      end
      OP_MFHI: res = m_hi;
      OP_MFLO: res = m_lo;
      default: res = '0;
    endcase
  endtask

  task automatic issue(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] er;
    logic eo, ed;
    int lat, busy_n, exp_lat;
    model(op, a, b, er, eo, ed);
    exp_lat = is_iter_op(op) ? W + 1 : 0;
    bus.start = 1'b1; bus.ALU_Control = op; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
    lat = 0; busy_n = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".busy_cycles"}, busy_n, is_iter_op(op) ? W + 1 : 0);
    check({tag, ".busy_at_done"}, bus.busy, 0);
    check({tag, ".res"}, bus.ALU_result, er);
    check({tag, ".zero"}, bus.zero, (er == 0));
    check({tag, ".ovf"}, bus.overflow, eo);
    check({tag, ".dz"}, bus.div_by_zero, ed);
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return $urandom_range(0, 20);
      5: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, ".busy"}, bus.busy, 0);
    check({tag, ".done"}, bus.done, 0);
    check({tag, ".res"}, bus.ALU_result, 0);
    check({tag, ".zero"}, bus.zero, 0);
    check({tag, ".ovf"}, bus.overflow, 0);
    check({tag, ".dz"}, bus.div_by_zero, 0);
  endtask

  initial begin
    logic [W-1:0] er;
    logic eo, ed;
    int lat;

    reset = 1'b1;
    bus.start = 1'b0; bus.ALU_Control = '0; bus.A = '0; bus.B = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_cleared("por");

    issue("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1);
    issue("sub_zero", OP_SUB, 5, 5);
    issue("sub_ovf", OP_SUB, 32'h8000_0000, 1);
    issue("slt", OP_SLT, 32'hFFFF_FFFF, 1);
    issue("sltu", OP_SLTU, 32'hFFFF_FFFF, 1);
    issue("xor", OP_XOR, 32'hF0F0_1234, 32'h0FF0_4321);
    issue("nor", OP_NOR, 32'h0000_FFFF, 32'h00FF_0000);
    issue("and", OP_AND, 32'hDEAD_BEEF, 32'h0F0F_F0F0);
    issue("or", OP_OR, 32'h1200_0034, 32'h0056_7800);
    issue("rsv", OP_RSV0, 32'h1234, 32'h5678);
    issue("mult", OP_MULT, -32'sd3, 32'd7);
    issue("mult.hi", OP_MFHI, 0, 0);
    issue("mult.lo", OP_MFLO, 0, 0);
    issue("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue("multu.hi", OP_MFHI, 0, 0);
    issue("div", OP_DIV, -32'sd7, 32'd2);
    issue("div.hi", OP_MFHI, 0, 0);
    issue("divu0", OP_DIVU, 9, 0);
    issue("divu0.hi", OP_MFHI, 0, 0);
    issue("div_min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    issue("div_min.hi", OP_MFHI, 0, 0);
    issue("div0_neg", OP_DIV, -32'sd5, 0);
    issue("div0_neg.hi", OP_MFHI, 0, 0);

    // Reset mid-MULT aborts without touching HI/LO.
    bus.start = 1'b1; bus.ALU_Control = OP_MULT; bus.A = 32'h1234_5678; bus.B = 32'h9ABC;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_cleared("rst_mid");
    m_hi = '0; m_lo = '0;
    issue("rst_mid.hi", OP_MFHI, 0, 0);
    issue("rst_mid.lo", OP_MFLO, 0, 0);

    // Start held during busy is ignored; MFLO started in the done cycle sees the new quotient.
    model(OP_DIV, 100, 7, er, eo, ed);
    bus.start = 1'b1; bus.ALU_Control = OP_DIV; bus.A = 100; bus.B = 7;
    @(posedge clk); #1;
    bus.ALU_Control = OP_ADD; bus.A = 1; bus.B = 2;
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b.lat", lat, W + 1);
    check("b2b.res", bus.ALU_result, er);
    bus.ALU_Control = OP_MFLO;
    model(OP_MFLO, 0, 0, er, eo, ed);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b.mflo_done", bus.done, 1);
    check("b2b.mflo_res", bus.ALU_result, er);
    @(posedge clk); #1;
    check("b2b.done_pulse", bus.done, 0);

    for (int i = 0; i < 80; i++) begin
      issue($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), rand_opnd(), rand_opnd());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
